ccr_unit: RTL and testbench

Condition-code register for the 8-bit pipelined processor. It holds the architectural flags {V, C, N, Z}, which are written by the execute stage and fed back to the ALU's `flags_in`. It evaluates conditional jumps against those flags and clears the tested flag when a jump is taken. For interrupt entry and RTI it provides a hardware shadow stack that saves and restores the flags.

---
 rtl/ccr_unit.sv | 103 ++++++++++
 tb/tb_ccr_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ccr_unit.sv
// Condition-code register {V, C, N, Z} with taken-jump flag clearing and a
// LIFO shadow stack that saves/restores the flags across interrupt entry/RTI.
module ccr_unit #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] flags_nxt,
  input  logic       flags_we,
  input  logic       br_valid,
  input  logic [1:0] br_cond,
  output logic       br_taken,
  input  logic       int_save,
  input  logic       rti_restore,
  output logic [3:0] flags,
  output logic       stk_full,
  output logic       stk_empty,
  output logic       stk_err
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_d;
  logic [3:0]    stk [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  logic [3:0] base;
  logic [3:0] flags_d;
  logic       collide;
  logic       push_ok;
  logic       pop_ok;
  logic       err_evt;

  // Jumps test the registered flags, so an ALU op followed directly by a
  // jump sees the ALU op's result in the jump's execute cycle.
  assign br_taken = br_valid & flags[br_cond];

  // NOTE: every always_comb output gets a default on entry so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    base = flags_we ? flags_nxt : flags;
    if (br_taken) begin
      base[br_cond] = 1'b0;
    end
  end

  assign collide = int_save & rti_restore;
  assign push_ok = int_save & ~rti_restore & ~stk_full;
  assign pop_ok  = rti_restore & ~int_save & ~stk_empty;
  assign err_evt = collide
                 | (int_save & stk_full)
                 | (rti_restore & stk_empty);

  assign wr_idx = ptr[IW-1:0];
  assign rd_idx = IW'(ptr - 1'b1);

  always_comb begin
    ptr_d   = ptr;
    flags_d = base;
    if (push_ok) begin
      ptr_d = ptr + 1'b1;
    end else if (pop_ok) begin
      ptr_d   = ptr - 1'b1;
      flags_d = stk[rd_idx];
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags     <= 4'b0000;
      ptr       <= '0;
      stk_full  <= 1'b0;
      stk_empty <= 1'b1;
      stk_err   <= 1'b0;
    end else begin
      flags     <= flags_d;
      ptr       <= ptr_d;
      stk_full  <= (ptr_d == PTR_MAX);
      stk_empty <= (ptr_d == '0);
      stk_err   <= stk_err | err_evt;
    end
  end

  // NOTE: the shadow stack is reset explicitly because a restore after reset
  // must never hand stale flags back to the pipeline; it is small enough to
  // live in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stk[i] <= 4'b0000;
      end
    end else if (push_ok) begin
      stk[wr_idx] <= base;
    end
  end

endmodule

// File: tb/tb_ccr_unit.sv
// Self-checking bench for ccr_unit: a queue-based flag/stack model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_ccr_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] flags_nxt;
  logic       flags_we;
  logic       br_valid;
  logic [1:0] br_cond;
  logic       br_taken;
  logic       int_save;
  logic       rti_restore;
  logic [3:0] flags;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  ccr_unit #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flags_nxt  (flags_nxt),
    .flags_we   (flags_we),
    .br_valid   (br_valid),
    .br_cond    (br_cond),
    .br_taken   (br_taken),
    .int_save   (int_save),
    .rti_restore(rti_restore),
    .flags      (flags),
    .stk_full   (stk_full),
    .stk_empty  (stk_empty),
    .stk_err    (stk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: flags as a plain value, shadow stack as a queue.
  logic [3:0] m_flags = 4'b0000;
  logic [3:0] m_stk[$];
  bit         m_err = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_flags = 4'b0000;
      m_err   = 1'b0;
      m_stk.delete();
    end else begin
      logic [3:0] nv;
      nv = flags_we ? flags_nxt : m_flags;
      if (br_valid && m_flags[br_cond]) nv[br_cond] = 1'b0;
      if (int_save && rti_restore) begin
        m_err = 1'b1;
      end else if (rti_restore) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else nv = m_stk.pop_back();
      end else if (int_save) begin
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else m_stk.push_back(nv);
      end
      m_flags = nv;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("mdl_flags", flags, m_flags);
      check("mdl_full", {3'b0, stk_full}, {3'b0, m_stk.size() == DEPTH});
      check("mdl_empty", {3'b0, stk_empty}, {3'b0, m_stk.size() == 0});
      check("mdl_err", {3'b0, stk_err}, {3'b0, m_err});
      check("mdl_br_taken", {3'b0, br_taken}, {3'b0, br_valid & m_flags[br_cond]});
    end
  end

  task automatic idle();
    flags_we = 1'b0; flags_nxt = 4'b0000; br_valid = 1'b0; br_cond = 2'd0;
    int_save = 1'b0; rti_restore = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] v);
    idle(); flags_we = 1'b1; flags_nxt = v; tick();
  endtask

  task automatic push(input logic [3:0] v);
    idle(); flags_we = 1'b1; flags_nxt = v; int_save = 1'b1; tick();
  endtask

  task automatic pop();
    idle(); rti_restore = 1'b1; tick();
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_flags", flags, 4'b0000);
    check("rst_empty", {3'b0, stk_empty}, 4'd1);
    check("rst_full", {3'b0, stk_full}, 4'd0);
    check("rst_err", {3'b0, stk_err}, 4'd0);
    tick();
    idle();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle();
    tick(); tick();
    armed = 1'b1;
    check("init_flags", flags, 4'b0000);
    check("init_empty", {3'b0, stk_empty}, 4'd1);
    reset = 1'b1;
    tick();

    // Write, then jump clear.
    wr(4'b1010);
    check("write", flags, 4'b1010);
    wr(4'b0101);
    idle(); br_valid = 1'b1; br_cond = 2'd0; #1;
    check("br_z_taken", {3'b0, br_taken}, 4'd1);
    tick();
    check("br_z_clear", flags, 4'b0100);
    idle(); br_valid = 1'b1; br_cond = 2'd3; #1;
    check("br_v_not_taken", {3'b0, br_taken}, 4'd0);
    tick();
    check("br_v_unchanged", flags, 4'b0100);
    idle(); br_valid = 1'b0; br_cond = 2'd2; #1;
    check("br_invalid", {3'b0, br_taken}, 4'd0);
    // Taken jump clear applies on top of a simultaneous write.
    idle(); br_valid = 1'b1; br_cond = 2'd2; flags_we = 1'b1; flags_nxt = 4'b1111; tick();
    check("br_clear_with_we", flags, 4'b1011);

    // Save pushes the next value, not the old flags.
    wr(4'b0001);
    push(4'b0110);
    check("save_flags", flags, 4'b0110);
    check("save_nonempty", {3'b0, stk_empty}, 4'd0);
    wr(4'b1111);
    pop();
    check("restore_val", flags, 4'b0110);
    check("restore_empty", {3'b0, stk_empty}, 4'd1);

    // Nesting to full, overflow, then unwind.
    push(4'b0001); push(4'b0010); push(4'b0011); push(4'b0100);
    check("full", {3'b0, stk_full}, 4'd1);
    check("full_no_err", {3'b0, stk_err}, 4'd0);
    push(4'b0101);
    check("ovf_err", {3'b0, stk_err}, 4'd1);
    check("ovf_flags", flags, 4'b0101);
    pop(); check("pop1", flags, 4'b0100);
    pop(); check("pop2", flags, 4'b0011);
    pop(); check("pop3", flags, 4'b0010);
    pop(); check("pop4", flags, 4'b0001);
    check("unwound_empty", {3'b0, stk_empty}, 4'd1);

    // Reset in the middle of a push discards it.
    idle(); flags_we = 1'b1; flags_nxt = 4'b1100; int_save = 1'b1;
    do_reset();
    check("post_rst_flags", flags, 4'b0000);

    // Pop when empty.
    idle(); rti_restore = 1'b1; flags_we = 1'b1; flags_nxt = 4'b1000; tick();
    check("underflow_flags", flags, 4'b1000);
    check("underflow_err", {3'b0, stk_err}, 4'd1);

    // Collision with one entry: pointer stays at one.
    do_reset();
    push(4'b0011);
    idle(); int_save = 1'b1; rti_restore = 1'b1; flags_we = 1'b1; flags_nxt = 4'b0111; tick();
    check("collide_flags", flags, 4'b0111);
    check("collide_err", {3'b0, stk_err}, 4'd1);
    check("collide_nonempty", {3'b0, stk_empty}, 4'd0);
    pop();
    check("collide_kept", flags, 4'b0011);
    check("collide_then_empty", {3'b0, stk_empty}, 4'd1);

    // Restore overrides a taken jump and a simultaneous write.
    push(4'b1001);
    idle(); rti_restore = 1'b1; br_valid = 1'b1; br_cond = 2'd0;
    flags_we = 1'b1; flags_nxt = 4'b0000; #1;
    check("prio_br_taken", {3'b0, br_taken}, 4'd1);
    tick();
    check("prio_restore", flags, 4'b1001);

    idle();
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
